// File: rtl/fp_pkg.sv
// GF(p) constants, GF(p^2) type and lazy-reduced add/sub for p = 5*2^248 - 1.
// All field values are kept in [0, 2p) in Montgomery form with R = 2^255.
package fp_pkg;

    localparam int FP_W = 255;

    localparam logic [FP_W-1:0] P           = (255'd5 << 248) - 255'd1;
    localparam logic [FP_W:0]   TWO_P       = {P, 1'b0};
    localparam logic [FP_W-1:0] MONT_ONE    = (255'd3 << 248) + 255'd25;
    // -p^-1 mod 2^255 collapses to p + 2 because p = -1 mod 2^248
    localparam logic [FP_W-1:0] MONT_NPRIME = P + 255'd2;

    typedef struct packed {
        logic [FP_W-1:0] re;
        logic [FP_W-1:0] im;
    } fp2_t;

    function automatic logic [FP_W-1:0] fp_add(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
        logic [FP_W+1:0] s;
        s = {2'b00, a} + {2'b00, b};
        if (s >= {1'b0, TWO_P}) s = s - {1'b0, TWO_P};
        return FP_W'(s);
    endfunction

    function automatic logic [FP_W-1:0] fp_sub(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
        logic [FP_W+1:0] d;
        d = {2'b00, a} - {2'b00, b};
        if (d[FP_W+1]) d = d + {1'b0, TWO_P};
        return FP_W'(d);
    endfunction

    function automatic fp2_t fp2_add(input fp2_t a, input fp2_t b);
        fp2_t r;
        r.re = fp_add(a.re, b.re);
        r.im = fp_add(a.im, b.im);
        return r;
    endfunction

    function automatic fp2_t fp2_sub(input fp2_t a, input fp2_t b);
        fp2_t r;
        r.re = fp_sub(a.re, b.re);
        r.im = fp_sub(a.im, b.im);
        return r;
    endfunction

endpackage

// File: rtl/fp2_sqr_pipe.sv
// GF(p^2) squarer: re = (re+im)(re-im), im = (2re)*im, LAT register stages total.
// One operand-prep stage feeds two Montgomery multipliers of latency LAT-1 (LAT >= 4).
module fp2_sqr_pipe import fp_pkg::*; #(
    parameter int LAT = 6
) (
    input  logic clk,
    input  logic rst,
    input  fp2_t a,
    output fp2_t y
);

    logic [FP_W:0]   sum_d, sum_q;
    logic [FP_W:0]   dif_d, dif_q;
    logic [FP_W-1:0] dbl_d, dbl_q;
    logic [FP_W-1:0] im_d, im_q;
    logic [FP_W-1:0] sq_re, sq_im;

    // re - im is biased by 2p so it stays non-negative; both factors remain < 4p
    always_comb begin
        sum_d = {1'b0, a.re} + {1'b0, a.im};
        dif_d = {1'b0, a.re} + TWO_P - {1'b0, a.im};
        dbl_d = fp_add(a.re, a.re);
        im_d  = a.im;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
            dif_q <= '0;
            dbl_q <= '0;
            im_q  <= '0;
        end else begin
            sum_q <= sum_d;
            dif_q <= dif_d;
            dbl_q <= dbl_d;
            im_q  <= im_d;
        end
    end

    fp_mont_mul #(.LAT(LAT - 1)) u_mul_re (
        .clk (clk),
        .rst (rst),
        .a   (sum_q),
        .b   (dif_q),
        .y   (sq_re)
    );

    fp_mont_mul #(.LAT(LAT - 1)) u_mul_im (
        .clk (clk),
        .rst (rst),
        .a   ({1'b0, dbl_q}),
        .b   ({1'b0, im_q}),
        .y   (sq_im)
    );

    assign y.re = sq_re;
    assign y.im = sq_im;

endmodule

// File: rtl/fp_mont_mul.sv
// Pipelined Montgomery multiplier, R = 2^255, operands < 4p, result in [0, 2p).
// Three compute stages (product, m, reduce) followed by LAT-3 pure delay stages.
module fp_mont_mul import fp_pkg::*; #(
    parameter int LAT = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W:0]   a,
    input  logic [FP_W:0]   b,
    output logic [FP_W-1:0] y
);

    localparam int PW = 2 * FP_W + 2;

    logic [PW-1:0]   t_d, t_q;
    logic [PW-1:0]   t2_d, t2_q;
    logic [FP_W-1:0] m_d, m_q;
    logic [FP_W-1:0] u_d [LAT-2];
    logic [FP_W-1:0] u_q [LAT-2];
    logic [PW-1:0]   acc;

    // With operands < 4p the reduced value stays below 2p, so no final subtract
    always_comb begin
        t_d  = {{(PW-FP_W-1){1'b0}}, a} * {{(PW-FP_W-1){1'b0}}, b};
        m_d  = t_q[FP_W-1:0] * MONT_NPRIME;
        t2_d = t_q;
        acc  = t2_q + {{(PW-FP_W){1'b0}}, m_q} * {{(PW-FP_W){1'b0}}, P};
        u_d[0] = FP_W'(acc >> FP_W);
        for (int i = 1; i < LAT - 2; i++) u_d[i] = u_q[i-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_q  <= '0;
            t2_q <= '0;
            m_q  <= '0;
            for (int i = 0; i < LAT - 2; i++) u_q[i] <= '0;
        end else begin
            t_q  <= t_d;
            t2_q <= t2_d;
            m_q  <= m_d;
            for (int i = 0; i < LAT - 2; i++) u_q[i] <= u_d[i];
        end
    end

    assign y = u_q[LAT-3];

endmodule

// File: rtl/fp2_theta_square_hadamard.sv
// Squared-theta transform: square x,y,z,t in GF(p^2), then 4-point Hadamard.
// Free-running pipeline with no handshake: a new point every clock, results LATENCY-1 edges later.
module fp2_theta_square_hadamard import fp_pkg::*; #(
    parameter int FP2_SQR_LATENCY = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] A1,
    input  logic [FP_W-1:0] B1,
    input  logic [FP_W-1:0] A2,
    input  logic [FP_W-1:0] B2,
    input  logic [FP_W-1:0] A3,
    input  logic [FP_W-1:0] B3,
    input  logic [FP_W-1:0] A4,
    input  logic [FP_W-1:0] B4,
    output logic [FP_W-1:0] D1_re,
    output logic [FP_W-1:0] D1_im,
    output logic [FP_W-1:0] D2_re,
    output logic [FP_W-1:0] D2_im,
    output logic [FP_W-1:0] D3_re,
    output logic [FP_W-1:0] D3_im,
    output logic [FP_W-1:0] D4_re,
    output logic [FP_W-1:0] D4_im
);

    localparam int LATENCY_FP2_TO_SQUARED_THETA = FP2_SQR_LATENCY + 2;
    localparam int SQR_LAT = LATENCY_FP2_TO_SQUARED_THETA - 2;

    fp2_t pt_in [4];
    fp2_t sq    [4];
    fp2_t s_d   [4];
    fp2_t s_q   [4];
    fp2_t h_d   [4];
    fp2_t h_q   [4];

    assign pt_in[0] = '{re: A1, im: B1};
    assign pt_in[1] = '{re: A2, im: B2};
    assign pt_in[2] = '{re: A3, im: B3};
    assign pt_in[3] = '{re: A4, im: B4};

    for (genvar g = 0; g < 4; g++) begin : g_sqr
        fp2_sqr_pipe #(.LAT(SQR_LAT)) u_sqr (
            .clk (clk),
            .rst (rst),
            .a   (pt_in[g]),
            .y   (sq[g])
        );
    end

    always_comb begin
        s_d[0] = fp2_add(sq[0], sq[1]);
        s_d[1] = fp2_sub(sq[0], sq[1]);
        s_d[2] = fp2_add(sq[2], sq[3]);
        s_d[3] = fp2_sub(sq[2], sq[3]);
        h_d[0] = fp2_add(s_q[0], s_q[2]);
        h_d[1] = fp2_add(s_q[1], s_q[3]);
        h_d[2] = fp2_sub(s_q[0], s_q[2]);
        h_d[3] = fp2_sub(s_q[1], s_q[3]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                s_q[i] <= '0;
                h_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                s_q[i] <= s_d[i];
                h_q[i] <= h_d[i];
            end
        end
    end

    assign D1_re = h_q[0].re;
    assign D1_im = h_q[0].im;
    assign D2_re = h_q[1].re;
    assign D2_im = h_q[1].im;
    assign D3_re = h_q[2].re;
    assign D3_im = h_q[2].im;
    assign D4_re = h_q[3].re;
    assign D4_im = h_q[3].im;

endmodule

// File: tb/tb_fp2_theta_square_hadamard.sv
// Bench for fp2_theta_square_hadamard: directed points with hand-derived residues,
// then random back-to-back points against an independent mod-p model.
module tb_fp2_theta_square_hadamard;

    localparam int FW = 255;
    localparam int L  = 8;
    localparam int W  = 1 + 8 * FW;

    localparam logic [FW-1:0] BP   = (255'd5 << 248) - 255'd1;
    localparam logic [FW:0]   B2P  = {BP, 1'b0};
    localparam logic [FW-1:0] MO   = (255'd3 << 248) + 255'd25;
    localparam logic [FW-1:0] NM   = (255'd2 << 248) - 255'd26;
    localparam logic [FW-1:0] TMO  = (255'd1 << 248) + 255'd51;
    localparam logic [FW-1:0] Z    = '0;

    logic clk = 1'b0;
    logic rst;
    logic [FW-1:0] A1, B1, A2, B2, A3, B3, A4, B4;
    logic [FW-1:0] D1_re, D1_im, D2_re, D2_im, D3_re, D3_im, D4_re, D4_im;

    logic         in_vld;
    logic [L-1:0] vld_sr;
    logic [W-1:0] exp_q [$];
    int           n_vec = 0;
    int           n_err = 0;
    string        nm [8] = '{"D1_re", "D1_im", "D2_re", "D2_im", "D3_re", "D3_im", "D4_re", "D4_im"};

    always #5 clk = ~clk;

    fp2_theta_square_hadamard dut (
        .clk   (clk),
        .rst   (rst),
        .A1    (A1),
        .B1    (B1),
        .A2    (A2),
        .B2    (B2),
        .A3    (A3),
        .B3    (B3),
        .A4    (A4),
        .B4    (B4),
        .D1_re (D1_re),
        .D1_im (D1_im),
        .D2_re (D2_re),
        .D2_im (D2_im),
        .D3_re (D3_re),
        .D3_im (D3_im),
        .D4_re (D4_re),
        .D4_im (D4_im)
    );

    // Tracks which output slots carry a scoreboarded point
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_sr <= '0;
        else      vld_sr <= {vld_sr[L-2:0], in_vld};
    end

    function automatic logic [FW-1:0] fmod(input logic [FW:0] v);
        return FW'(v % {1'b0, BP});
    endfunction

    function automatic logic [FW-1:0] fadd(input logic [FW-1:0] a, input logic [FW-1:0] b);
        return fmod({1'b0, a} + {1'b0, b});
    endfunction

    function automatic logic [FW-1:0] fsub(input logic [FW-1:0] a, input logic [FW-1:0] b);
        return fmod({1'b0, a} + {1'b0, BP} - {1'b0, b});
    endfunction

    // a*b*2^-255 mod p, via a plain product and 255 modular halvings
    function automatic logic [FW-1:0] mmul(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [511:0] pr;
        logic [255:0] r;
        pr = ({257'b0, a} * {257'b0, b}) % {257'b0, BP};
        r = 256'(pr);
        repeat (255) begin
            if (r[0]) r = r + {1'b0, BP};
            r = r >> 1;
        end
        return FW'(r);
    endfunction

    function automatic logic [8*FW-1:0] model(input logic [8*FW-1:0] pt);
        logic [FW-1:0] re [4], im [4], sr [4], si [4], hr [4], hi [4];
        logic [8*FW-1:0] r;
        for (int k = 0; k < 4; k++) begin
            re[k] = fmod({1'b0, pt[(7-2*k)*FW +: FW]});
            im[k] = fmod({1'b0, pt[(6-2*k)*FW +: FW]});
            sr[k] = mmul(fadd(re[k], im[k]), fsub(re[k], im[k]));
            si[k] = mmul(fadd(re[k], re[k]), im[k]);
        end
        hr[0] = fadd(fadd(sr[0], sr[1]), fadd(sr[2], sr[3]));
        hi[0] = fadd(fadd(si[0], si[1]), fadd(si[2], si[3]));
        hr[1] = fadd(fsub(sr[0], sr[1]), fsub(sr[2], sr[3]));
        hi[1] = fadd(fsub(si[0], si[1]), fsub(si[2], si[3]));
        hr[2] = fsub(fadd(sr[0], sr[1]), fadd(sr[2], sr[3]));
        hi[2] = fsub(fadd(si[0], si[1]), fadd(si[2], si[3]));
        hr[3] = fsub(fsub(sr[0], sr[1]), fsub(sr[2], sr[3]));
        hi[3] = fsub(fsub(si[0], si[1]), fsub(si[2], si[3]));
        for (int k = 0; k < 4; k++) begin
            r[(7-2*k)*FW +: FW] = hr[k];
            r[(6-2*k)*FW +: FW] = hi[k];
        end
        return r;
    endfunction

    function automatic logic [FW-1:0] rnd_fe();
        logic [255:0] r;
        r = '0;
        repeat (8) r = {r[223:0], 32'($urandom())};
        return FW'(r % {1'b0, B2P});
    endfunction

    function automatic logic [8*FW-1:0] rnd_pt();
        logic [8*FW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*FW +: FW] = rnd_fe();
        return r;
    endfunction

    task automatic drive(input logic [8*FW-1:0] pt, input logic [W-1:0] exp_v);
        @(posedge clk);
        #2;
        {A1, B1, A2, B2, A3, B3, A4, B4} = pt;
        in_vld = 1'b1;
        exp_q.push_back(exp_v);
    endtask

    task automatic drive_junk();
        @(posedge clk);
        #2;
        {A1, B1, A2, B2, A3, B3, A4, B4} = rnd_pt();
        in_vld = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        logic [8*FW-1:0] got;
        got = {D1_re, D1_im, D2_re, D2_im, D3_re, D3_im, D4_re, D4_im};
        n_vec++;
        if (got != '0) begin
            n_err++;
            $display("FAIL %s: outputs not all zero, D1_re=%h D1_im=%h required 0", tag, D1_re, D1_im);
        end
    endtask

    // Monitor: pops the scoreboard whenever a tracked point reaches the outputs
    always @(negedge clk) begin : mon
        logic [W-1:0]    e;
        logic [8*FW-1:0] got;
        logic [FW-1:0]   g, ev;
        logic            ok;
        if (vld_sr[L-1]) begin
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got D1_re=%h with empty scoreboard", D1_re);
            end else begin
                e = exp_q.pop_front();
                got = {D1_re, D1_im, D2_re, D2_im, D3_re, D3_im, D4_re, D4_im};
                n_vec++;
                for (int i = 0; i < 8; i++) begin
                    g  = got[(7-i)*FW +: FW];
                    ev = e[(7-i)*FW +: FW];
                    ok = ({1'b0, g} < B2P) && (e[W-1] ? (g == ev) : (fmod({1'b0, g}) == ev));
                    if (!ok) begin
                        n_err++;
                        $display("FAIL %s vec %0d: got %h required %h (%s)", nm[i], n_vec, g, ev,
                                 e[W-1] ? "exact" : "mod p, below 2p");
                    end
                end
            end
        end
    end

    initial begin : main
        int waited;
        logic [8*FW-1:0] pt;
        in_vld = 1'b0;
        {A1, B1, A2, B2, A3, B3, A4, B4} = '0;
        rst = 1'b1;
        #1 rst = 1'b0;

        repeat (4) begin
            drive_junk();
            @(negedge clk);
            check_zero("reset_hold");
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (L - 1) begin
            @(negedge clk);
            check_zero("after_release");
            drive_junk();
        end

        drive('0, {1'b1, 2040'b0});
        drive({MO, Z, Z, Z, Z, Z, Z, Z}, {1'b0, MO, Z, MO, Z, MO, Z, MO, Z});
        drive({Z, MO, Z, Z, Z, Z, Z, Z}, {1'b0, NM, Z, NM, Z, NM, Z, NM, Z});
        drive({Z, Z, MO, Z, Z, Z, Z, Z}, {1'b0, MO, Z, NM, Z, MO, Z, NM, Z});
        drive({Z, Z, Z, Z, MO, Z, Z, Z}, {1'b0, MO, Z, MO, Z, NM, Z, NM, Z});
        drive({Z, Z, Z, Z, Z, Z, MO, Z}, {1'b0, MO, Z, NM, Z, NM, Z, MO, Z});
        drive({MO + BP, Z, Z, Z, Z, Z, Z, Z}, {1'b0, MO, Z, MO, Z, MO, Z, MO, Z});
        drive({BP, BP, BP, BP, BP, BP, BP, BP}, {1'b0, 2040'b0});
        drive({MO, Z, MO, Z, Z, Z, Z, Z}, {1'b0, TMO, Z, Z, Z, TMO, Z, Z, Z});
        drive({MO, MO, Z, Z, Z, Z, Z, Z}, {1'b0, Z, TMO, Z, TMO, Z, TMO, Z, TMO});

        repeat (100) begin
            pt = rnd_pt();
            drive(pt, {1'b0, model(pt)});
        end

        // Reset with points in flight: they must all be discarded
        repeat (3) begin
            pt = rnd_pt();
            drive(pt, {1'b0, model(pt)});
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        in_vld = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_zero("midstream_reset");
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive({MO, Z, Z, Z, Z, Z, Z, Z}, {1'b0, MO, Z, MO, Z, MO, Z, MO, Z});
        drive({Z, Z, Z, Z, Z, Z, MO, Z}, {1'b0, MO, Z, NM, Z, NM, Z, MO, Z});
        @(posedge clk);
        #2;
        in_vld = 1'b0;

        waited = 0;
        while (exp_q.size() != 0 && waited < 4 * L) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d points outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
